// File: rtl/clock_pkg.sv
// clock_pkg: shared BCD constants, converter state encoding and digit check
package clock_pkg;

    localparam int BCD_DIGITS = 8;

    typedef enum logic {IDLE, CONV} state_t;

    function automatic logic bcd_digit_valid(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: reverse double-dabble correction, subtract 3 from a digit >= 8
module bcd_digit_adjust (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = digit_i[3] ? digit_i - 4'd3 : digit_i;

endmodule

// File: rtl/bcd_to_unsigned.sv
// bcd_to_unsigned: sequential reverse double-dabble, packed BCD to unsigned binary
module bcd_to_unsigned
    import clock_pkg::*;
#(
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                idle,
    output logic                done,
    output logic                error,
    output logic [4*DIGITS-1:0] result
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(W);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   bcd_q, bcd_d, bin_q, bin_d, result_q, result_d;
    logic           done_q, done_d, error_q, error_d;
    logic [W-1:0]   bcd_shift, bcd_adj, bin_shift;
    logic [DIGITS-1:0] nib_ok;

    // One combined shift of {bcd, bin} followed by per-digit correction
    assign bcd_shift = {1'b0, bcd_q[W-1:1]};
    assign bin_shift = {bcd_q[0], bin_q[W-1:1]};

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_digit_adjust u_adj (
            .digit_i(bcd_shift[4*i +: 4]),
            .digit_o(bcd_adj[4*i +: 4])
        );
        assign nib_ok[i] = bcd_digit_valid(bcd_in[4*i +: 4]);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        result_d = result_q;
        error_d  = error_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (start && &nib_ok) begin
                bcd_d   = bcd_in;
                bin_d   = '0;
                cnt_d   = '0;
                state_d = CONV;
            end else if (start) begin
                done_d   = 1'b1;
                error_d  = 1'b1;
                result_d = '0;
            end
        end else begin
            bcd_d = bcd_adj;
            bin_d = bin_shift;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
                result_d = bin_shift;
                done_d   = 1'b1;
                error_d  = 1'b0;
                state_d  = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bcd_q    <= '0;
            bin_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            result_q <= result_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign idle   = (state_q == IDLE);
    assign done   = done_q;
    assign error  = error_q;
    assign result = result_q;

endmodule
